demux1x8_reg: RTL and testbench
===============================

Name: demux1x8_reg

Overview:
- Registered 1-to-8 demultiplexer; the distribution-side counterpart of the 8-to-1 selector.
- Steers a w-bit input word into one of eight held output lanes, chosen either by an external select or by an internal round-robin pointer.
- Tracks which lanes hold fresh data since the last clear, and flags when all eight are filled.
- Feeds parallel consumers, e.g. an 8-lane register bank reassembled from a serial word stream.

Parameters:
w, 1, data width of the input word and of each output lane

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- d  input  w  data word to distribute
- sel  input  3  lane select, used when auto=0
- load  input  1  write strobe; d is captured into the target lane this edge
- auto  input  1  1 = target is the internal pointer ptr; 0 = target is sel
- clear  input  1  restarts a frame: clears fill mask, pointer, full
- y0..y7  output  w each  held lane registers
- strobe  output  8  one-hot; bit k high one cycle after lane k was written
- ptr  output  3  current auto-mode pointer
- full  output  1  all eight lanes written since last clear/reset
- err  output  1  overwrite-protect violation pulse (Optional Feature)

Behaviour:
Reset:
- rst sampled on the clk edge.
- y0..y7=0, strobe=0, ptr=0, internal fill mask=8'h00, full=0, err=0.
- rst overrides every other input.

Priority per edge: rst > clear > load.

clear=1 (rst=0):
- Sets mask=0, ptr=0, full=0, strobe=0, err=0.
- y0..y7 retain their values.
- A simultaneous load is ignored entirely: no lane write, no pointer advance.

load=1 (rst=0, clear=0):
- Target t = auto ? ptr : sel.
- y[t] <= d; mask[t] <= 1; strobe <= (8'b1 << t).
- If auto=1, ptr <= ptr+1, wrapping 7 to 0.
- If auto=0, ptr is unchanged.

load=0:
- strobe <= 0; all other state holds.

Latency:
- y[t], strobe and ptr update on the same edge that samples load, visible one cycle after load is presented.

full:
- Registered; equals &mask after the edge.
- Rises in the cycle following the load that sets the last unset mask bit.
- Stays high until clear or rst.
- Further loads after full still write lanes (unless the Optional Feature blocks them); full stays 1.

Mode switching:
- auto may change on any cycle; ptr is unaffected by loads made with auto=0.
- Repeated writes to one lane in manual mode overwrite y and leave mask bits otherwise unchanged.

Optional Feature:
Macro: DEMUX1X8_REG_PROTECT_EN

Defined:
- A load whose target t already has mask[t]=1 is dropped: y, mask and strobe are unchanged (strobe <= 0).
- In auto mode ptr still advances.
- err pulses 1 for exactly one cycle after the offending edge.
- clear re-arms all lanes.

Undefined:
- Overwrites are always accepted.
- err is tied to 0.

Test Plan:
1. Reset: w=8, drive junk on d/sel/load with rst=1 for 2 cycles -> y0..y7=0, strobe=0, ptr=0, full=0, err=0.
2. Manual mode: auto=0; load d=8'hA5 sel=3, then d=8'h5A sel=6 -> y3=A5, y6=5A, other lanes 0, strobe=8'h08 then 8'h40, ptr stays 0, full=0.
3. Auto fill: clear, then auto=1 with 8 consecutive loads d=0x10..0x17 -> yk=0x10+k, ptr wraps to 0; full=1 exactly one cycle after the 8th load, not before.
4. Priority: clear=1 and load=1 (auto=1, d=8'hFF) on the same edge -> no lane change, ptr=0, full=0; rst=1 with load=1 -> all outputs 0.
5. Overwrite: sel=2 load 8'h11, then sel=2 load 8'h22
   - Without macro: y2=22, err=0.
   - With DEMUX1X8_REG_PROTECT_EN: y2=11, strobe=0, err high exactly one cycle.
6. Mid-frame reset: 4 auto loads, then rst one cycle, then 1 auto load d=8'h77 -> y0=77, y1..y7=0, ptr=1, full=0.

Source files
------------

// File: rtl/demux1x8_reg.sv
// -----------------------------------------------------------------------------
// demux1x8_reg
//
// Registered 1-to-8 demultiplexer. A w-bit word is steered into one of eight
// held output lanes, selected either by the external sel input (auto=0) or by
// an internal round-robin pointer (auto=1). A fill mask records which lanes
// have been written since the last clear/reset; full flags when all eight are
// filled.
//
// Optional feature (compile-time macro DEMUX1X8_REG_PROTECT_EN):
//   When defined, a load to a lane that is already filled is dropped (lane,
//   mask and strobe unchanged) and err pulses high for one cycle. In auto mode
//   the pointer still advances past the protected lane. When undefined,
//   overwrites are always accepted and err is tied low.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   synchronous active-high reset (overrides all inputs)
//   d       in   w   data word to distribute
//   sel     in   3   lane select, used when auto=0
//   load    in   1   write strobe; d is captured into the target lane
//   auto    in   1   1 = target is ptr, 0 = target is sel
//   clear   in   1   restart a frame: clears fill mask, ptr, full, strobe, err
//   y0..y7  out  w   held lane registers
//   strobe  out  8   one-hot, bit k high the cycle after lane k was written
//   ptr     out  3   current auto-mode pointer
//   full    out  1   all eight lanes written since last clear/reset
//   err     out  1   overwrite-protect violation pulse
//
// Priority on each edge: rst > clear > load.
// -----------------------------------------------------------------------------
module demux1x8_reg #(
  parameter int w = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [w-1:0] d,
  input  logic [2:0]   sel,
  input  logic         load,
  input  logic         auto,
  input  logic         clear,
  output logic [w-1:0] y0,
  output logic [w-1:0] y1,
  output logic [w-1:0] y2,
  output logic [w-1:0] y3,
  output logic [w-1:0] y4,
  output logic [w-1:0] y5,
  output logic [w-1:0] y6,
  output logic [w-1:0] y7,
  output logic [7:0]   strobe,
  output logic [2:0]   ptr,
  output logic         full,
  output logic         err
);

  // Lane storage as a packed 2-D array so the whole bank can be indexed by
  // the 3-bit target.
  logic [7:0][w-1:0] lanes;
  logic [7:0]        mask;

  // Combinational decode of the current edge's write.
  logic [2:0] target;
  logic       blocked;
  logic       write_en;
  logic [7:0] mask_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    target    = auto ? ptr : sel;
`ifdef DEMUX1X8_REG_PROTECT_EN
    // A lane already filled in this frame is write-protected.
    blocked   = load & mask[target];
`else
    blocked   = 1'b0;
`endif
    // clear wins over load: a simultaneous load has no effect at all.
    write_en  = load & ~clear & ~blocked;
    mask_next = mask;
    if (write_en) begin
      mask_next[target] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // The lane bank is reset along with the control state because the lane
  // outputs are required to read zero after reset; clear deliberately leaves
  // the lanes untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes  <= '0;
      mask   <= '0;
      strobe <= '0;
      ptr    <= '0;
      full   <= 1'b0;
    end else if (clear) begin
      mask   <= '0;
      strobe <= '0;
      ptr    <= '0;
      full   <= 1'b0;
    end else begin
      if (write_en) begin
        lanes[target] <= d;
      end
      mask   <= mask_next;
      // full reflects the mask as it stands after this edge.
      full   <= &mask_next;
      strobe <= write_en ? (8'b1 << target) : 8'b0;
      // The pointer steps on every auto-mode load, including a protected
      // (dropped) one, so the round-robin order is never disturbed.
      if (load && auto) begin
        ptr <= ptr + 3'd1;
      end
    end
  end

`ifdef DEMUX1X8_REG_PROTECT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_q <= 1'b0;
    end else begin
      err_q <= blocked;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign y0 = lanes[0];
  assign y1 = lanes[1];
  assign y2 = lanes[2];
  assign y3 = lanes[3];
  assign y4 = lanes[4];
  assign y5 = lanes[5];
  assign y6 = lanes[6];
  assign y7 = lanes[7];

endmodule

// File: tb/tb_demux1x8_reg.sv
// -----------------------------------------------------------------------------
// tb_demux1x8_reg
//
// Directed self-checking bench for demux1x8_reg with w=8. Expected values are
// hand-computed constants. Inputs are driven 1 time unit after the rising
// edge and outputs are sampled at that same point, i.e. away from the edge.
// Build with +define+DEMUX1X8_REG_PROTECT_EN to check the protected variant.
// -----------------------------------------------------------------------------
module tb_demux1x8_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] d;
  logic [2:0]   sel;
  logic         load;
  logic         auto;
  logic         clear;
  logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]   strobe;
  logic [2:0]   ptr;
  logic         full;
  logic         err;

  logic [W-1:0] yv [8];

  int n_checks = 0;
  int n_errors = 0;

  demux1x8_reg #(.w(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .sel    (sel),
    .load   (load),
    .auto   (auto),
    .clear  (clear),
    .y0     (y0),
    .y1     (y1),
    .y2     (y2),
    .y3     (y3),
    .y4     (y4),
    .y5     (y5),
    .y6     (y6),
    .y7     (y7),
    .strobe (strobe),
    .ptr    (ptr),
    .full   (full),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    yv[0] = y0; yv[1] = y1; yv[2] = y2; yv[3] = y3;
    yv[4] = y4; yv[5] = y5; yv[6] = y6; yv[7] = y7;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(input string tag, input logic [W-1:0] exp [8]);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s y%0d", tag, k), 32'(yv[k]), 32'(exp[k]));
    end
  endtask

  logic [W-1:0] exp_lanes [8];

  initial begin
    // ---- 1. Reset with junk on the inputs ----
    rst = 1'b1; d = 8'hC3; sel = 3'd5; load = 1'b1; auto = 1'b1; clear = 1'b0;
    step();
    d = 8'h3C; sel = 3'd2;
    step();
    for (int k = 0; k < 8; k++) exp_lanes[k] = '0;
    check_lanes("reset", exp_lanes);
    check("reset strobe", 32'(strobe), 32'h00);
    check("reset ptr",    32'(ptr),    32'd0);
    check("reset full",   32'(full),   32'd0);
    check("reset err",    32'(err),    32'd0);

    // ---- 2. Manual mode ----
    rst = 1'b0; auto = 1'b0; load = 1'b1; d = 8'hA5; sel = 3'd3;
    step();
    check("man1 y3",     32'(y3),     32'hA5);
    check("man1 strobe", 32'(strobe), 32'h08);
    check("man1 ptr",    32'(ptr),    32'd0);
    d = 8'h5A; sel = 3'd6;
    step();
    exp_lanes[3] = 8'hA5; exp_lanes[6] = 8'h5A;
    check_lanes("man2", exp_lanes);
    check("man2 strobe", 32'(strobe), 32'h40);
    check("man2 ptr",    32'(ptr),    32'd0);
    check("man2 full",   32'(full),   32'd0);
    load = 1'b0;
    step();
    check("idle strobe", 32'(strobe), 32'h00);

    // ---- 3. Auto fill ----
    clear = 1'b1;
    step();
    check("clear y3 kept", 32'(y3),   32'hA5);
    check("clear ptr",     32'(ptr),  32'd0);
    check("clear full",    32'(full), 32'd0);
    clear = 1'b0; auto = 1'b1; load = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = 8'(8'h10 + k);
      step();
      check($sformatf("auto%0d ptr", k),    32'(ptr),    32'((k + 1) % 8));
      check($sformatf("auto%0d strobe", k), 32'(strobe), 32'(1 << k));
      check($sformatf("auto%0d full", k),   32'(full),   32'(k == 7));
    end
    for (int k = 0; k < 8; k++) exp_lanes[k] = 8'(8'h10 + k);
    check_lanes("auto", exp_lanes);
    load = 1'b0;
    step();
    check("full holds",  32'(full),   32'd1);
    check("auto strobe", 32'(strobe), 32'h00);

    // ---- 4. Priority ----
    clear = 1'b1; load = 1'b1; auto = 1'b1; d = 8'hFF;
    step();
    check_lanes("clr+load", exp_lanes);
    check("clr+load ptr",    32'(ptr),    32'd0);
    check("clr+load full",   32'(full),   32'd0);
    check("clr+load strobe", 32'(strobe), 32'h00);
    clear = 1'b0; rst = 1'b1; load = 1'b1;
    step();
    for (int k = 0; k < 8; k++) exp_lanes[k] = '0;
    check_lanes("rst+load", exp_lanes);
    check("rst+load ptr",    32'(ptr),    32'd0);
    check("rst+load strobe", 32'(strobe), 32'h00);
    check("rst+load full",   32'(full),   32'd0);
    rst = 1'b0; load = 1'b0;

    // ---- 5. Overwrite ----
    auto = 1'b0; sel = 3'd2; d = 8'h11; load = 1'b1;
    step();
    check("ow1 y2",  32'(y2),  32'h11);
    check("ow1 err", 32'(err), 32'd0);
    d = 8'h22;
    step();
`ifdef DEMUX1X8_REG_PROTECT_EN
    check("ow2 y2",     32'(y2),     32'h11);
    check("ow2 strobe", 32'(strobe), 32'h00);
    check("ow2 err",    32'(err),    32'd1);
`else
    check("ow2 y2",     32'(y2),     32'h22);
    check("ow2 strobe", 32'(strobe), 32'h04);
    check("ow2 err",    32'(err),    32'd0);
`endif
    load = 1'b0;
    step();
    check("ow3 err", 32'(err), 32'd0);

    // ---- 6. Mid-frame reset ----
    clear = 1'b1;
    step();
    clear = 1'b0; auto = 1'b1; load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'(8'h30 + k);
      step();
    end
    check("mid ptr", 32'(ptr), 32'd4);
    check("mid y3",  32'(y3),  32'h33);
    rst = 1'b1; load = 1'b0;
    step();
    rst = 1'b0; load = 1'b1; d = 8'h77;
    step();
    for (int k = 0; k < 8; k++) exp_lanes[k] = '0;
    exp_lanes[0] = 8'h77;
    check_lanes("post-rst", exp_lanes);
    check("post-rst ptr",    32'(ptr),    32'd1);
    check("post-rst full",   32'(full),   32'd0);
    check("post-rst strobe", 32'(strobe), 32'h01);
    load = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
